diff_obuft_serial_bank: RTL and testbench

//  Parametrised multi-lane differential transmitter built on OBUFTDS pads. Each lane

---
 rtl/diff_obuft_serial_bank.sv | 199 +++++++++++++++++++
 tb/tb_diff_obuft_serial_bank.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/diff_obuft_serial_bank.sv
// diff_obuft_serial_bank
// Multi-lane differential transmitter. Each lane shifts a parallel word out
// LSB-first onto its own P/N pad pair. A small sequencer wraps each burst with
// GUARD cycles of IDLE_LEVEL and releases the pads to Hi-Z between bursts.
//
// Build options:
//   DIFF_OBUFT_PARITY_EN - adds one extra pad pair (index LANES) carrying the
//                          even parity of all lane bits while shifting.
//   DIFF_OBUFT_UNISIM    - instantiates vendor OBUFTDS primitives; otherwise
//                          the pads are modelled with equivalent tristate logic.
//
// Handshake: a word transfers on a rising clk edge where in_valid && in_ready.
// in_ready does not depend on in_valid. While in_ready is low, in_valid and
// in_data are ignored.
//
// Pad data and tristate enable are registered, so every pad change appears
// one cycle after the edge that caused it. state_dbg exposes the sequencer
// state (0=IDLE, 1=PRE, 2=SHIFT, 3=POST).
module diff_obuft_serial_bank #(
    parameter int    LANES      = 2,
    parameter int    WIDTH      = 8,
    parameter int    GUARD      = 2,
    parameter logic  IDLE_LEVEL = 1'b0,
    parameter string IOSTANDARD = "DIFF_SSTL135",
    parameter string SLEW       = "FAST"
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LANES*WIDTH-1:0]   in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     busy,
`ifdef DIFF_OBUFT_PARITY_EN
    output logic [LANES:0]           diff_p,
    output logic [LANES:0]           diff_n,
`else
    output logic [LANES-1:0]         diff_p,
    output logic [LANES-1:0]         diff_n,
`endif
    output logic [1:0]               state_dbg
);

`ifdef DIFF_OBUFT_PARITY_EN
    localparam int NPADS = LANES + 1;
`else
    localparam int NPADS = LANES;
`endif

    localparam int DW = LANES * WIDTH;
    localparam int BW = $clog2(WIDTH);
    localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

    localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'((GUARD > 0) ? (GUARD - 1) : 0);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRE   = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_POST  = 2'd3;

    logic [1:0]       state;
    logic [DW-1:0]    shift_reg;
    logic [BW-1:0]    bit_cnt;
    logic [GW-1:0]    guard_cnt;
    logic [NPADS-1:0] pad_o;
    logic             pad_t;

    logic [1:0]       nxt_state;
    logic [DW-1:0]    nxt_shift;
    logic [BW-1:0]    nxt_bit;
    logic [GW-1:0]    nxt_guard;
    logic [LANES-1:0] nxt_lane_bits;
    logic [NPADS-1:0] nxt_pad_o;
    logic             nxt_pad_t;
    logic             accept;

    // Ready only in IDLE or on the last bit of a word, never during reset.
    assign in_ready  = !rst && ((state == S_IDLE) ||
                                ((state == S_SHIFT) && (bit_cnt == BIT_LAST)));
    assign accept    = in_valid && in_ready;
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    // Next-state, shifter and counter logic for the burst sequencer.
    always_comb begin
        nxt_state = state;
        nxt_shift = shift_reg;
        nxt_bit   = bit_cnt;
        nxt_guard = guard_cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    nxt_shift = in_data;
                    nxt_bit   = '0;
                    nxt_guard = '0;
                    nxt_state = (GUARD > 0) ? S_PRE : S_SHIFT;
                end
            end
            S_PRE: begin
                if (guard_cnt == GUARD_LAST) begin
                    nxt_guard = '0;
                    nxt_bit   = '0;
                    nxt_state = S_SHIFT;
                end else begin
                    nxt_guard = guard_cnt + GW'(1);
                end
            end
            S_SHIFT: begin
                if (bit_cnt == BIT_LAST) begin
                    nxt_bit = '0;
                    if (accept) begin
                        // Chain straight into the next word: no gap, no guard.
                        nxt_shift = in_data;
                    end else begin
                        nxt_shift = '0;
                        nxt_guard = '0;
                        nxt_state = (GUARD > 0) ? S_POST : S_IDLE;
                    end
                end else begin
                    nxt_bit = bit_cnt + BW'(1);
                    for (int l = 0; l < LANES; l++) begin
                        nxt_shift[l*WIDTH +: WIDTH] = {1'b0, shift_reg[l*WIDTH+1 +: WIDTH-1]};
                    end
                end
            end
            default: begin
                if (guard_cnt == GUARD_LAST) begin
                    nxt_guard = '0;
                    nxt_state = S_IDLE;
                end else begin
                    nxt_guard = guard_cnt + GW'(1);
                end
            end
        endcase
    end

    // Pad values for the cycle after this edge, derived from the next state.
    always_comb begin
        nxt_pad_t = (nxt_state == S_IDLE);
        nxt_pad_o = {NPADS{IDLE_LEVEL}};
        for (int l = 0; l < LANES; l++) begin
            nxt_lane_bits[l] = nxt_shift[l*WIDTH];
        end
        if (nxt_state == S_SHIFT) begin
            nxt_pad_o[LANES-1:0] = nxt_lane_bits;
`ifdef DIFF_OBUFT_PARITY_EN
            nxt_pad_o[LANES] = ^nxt_lane_bits;
`endif
        end
    end

    // Sequencer state and registered pad drive; reset aborts any burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            guard_cnt <= '0;
            pad_o     <= '0;
            pad_t     <= 1'b1;
        end else begin
            state     <= nxt_state;
            shift_reg <= nxt_shift;
            bit_cnt   <= nxt_bit;
            guard_cnt <= nxt_guard;
            pad_o     <= nxt_pad_o;
            pad_t     <= nxt_pad_t;
        end
    end

    // Differential output pads, all sharing one tristate control.
    for (genvar p = 0; p < NPADS; p++) begin : g_pad
`ifdef DIFF_OBUFT_UNISIM
        OBUFTDS #(
            .IOSTANDARD(IOSTANDARD),
            .SLEW      (SLEW)
        ) u_obuftds (
            .O (diff_p[p]),
            .OB(diff_n[p]),
            .I (pad_o[p]),
            .T (pad_t)
        );
`else
        assign diff_p[p] = pad_t ? 1'bz : pad_o[p];
        assign diff_n[p] = pad_t ? 1'bz : ~pad_o[p];
`endif
    end

`ifndef DIFF_OBUFT_UNISIM
    // Catch pad attributes that the vendor primitive would reject.
    if (SLEW != "FAST" && SLEW != "SLOW") begin : g_bad_slew
        $error("diff_obuft_serial_bank: SLEW must be FAST or SLOW");
    end
    if (IOSTANDARD == "") begin : g_bad_iostd
        $error("diff_obuft_serial_bank: IOSTANDARD must not be empty");
    end
`endif

endmodule

// File: tb/tb_diff_obuft_serial_bank.sv
// Directed bench for diff_obuft_serial_bank: reset, single burst with guards,
// back-to-back words, mid-burst reset, GUARD=0 instance and optional parity.
module tb_diff_obuft_serial_bank;

`ifdef DIFF_OBUFT_PARITY_EN
  localparam int NP  = 3;
  localparam int NP2 = 2;
`else
  localparam int NP  = 2;
  localparam int NP2 = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        busy;
  logic [NP-1:0] diff_p;
  logic [NP-1:0] diff_n;
  logic [1:0]  state_dbg;

  logic [3:0]  in_data2;
  logic        in_valid2;
  logic        in_ready2;
  logic        busy2;
  logic [NP2-1:0] diff_p2;
  logic [NP2-1:0] diff_n2;
  logic [1:0]  state_dbg2;

  int n_tests = 0;
  int n_fail  = 0;

  diff_obuft_serial_bank #(
    .LANES(2), .WIDTH(8), .GUARD(2), .IDLE_LEVEL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .busy(busy), .diff_p(diff_p), .diff_n(diff_n),
    .state_dbg(state_dbg)
  );

  diff_obuft_serial_bank #(
    .LANES(1), .WIDTH(4), .GUARD(0), .IDLE_LEVEL(1'b0)
  ) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .busy(busy2), .diff_p(diff_p2), .diff_n(diff_n2),
    .state_dbg(state_dbg2)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 16'hFFFF;
    in_valid2 = 1'b1; in_data2 = 4'hF;
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++;
      if (dut.pad_t !== 1'b1) begin n_fail++; $display("FAIL reset_t c=%0d got %b want 1", c, dut.pad_t); end
      n_tests++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready c=%0d got %b want 0", c, in_ready); end
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy c=%0d got %b want 0", c, busy); end
      n_tests++;
      if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state c=%0d got %0d want 0", c, state_dbg); end
      n_tests++;
      if (dut2.pad_t !== 1'b1 || in_ready2 !== 1'b0) begin
        n_fail++; $display("FAIL reset_dut2 c=%0d got t=%b rdy=%b want t=1 rdy=0", c, dut2.pad_t, in_ready2);
      end
    end
    in_valid = 1'b0; in_valid2 = 1'b0; rst = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || in_ready2 !== 1'b1) begin
      n_fail++; $display("FAIL release_ready got %b/%b want 1/1", in_ready, in_ready2);
    end
  endtask

  task automatic test_single();
    logic [1:0] exp_p [13];
    logic [1:0] exp_s [13];
    exp_p = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b11, 2'b01, 2'b01, 2'b11, 2'b00, 2'b10,
              2'b00, 2'b00, 2'b00};
    exp_s = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
              2'd3, 2'd3, 2'd0};
    in_data = 16'hA53C; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (i > 0) step();
      n_tests++;
      if (dut.pad_t !== (i == 12)) begin n_fail++; $display("FAIL single_t i=%0d got %b want %b", i, dut.pad_t, (i == 12)); end
      n_tests++;
      if (busy !== (i < 12)) begin n_fail++; $display("FAIL single_busy i=%0d got %b want %b", i, busy, (i < 12)); end
      n_tests++;
      if (state_dbg !== exp_s[i]) begin n_fail++; $display("FAIL single_state i=%0d got %0d want %0d", i, state_dbg, exp_s[i]); end
      if (i < 12) begin
        n_tests++;
        if (diff_p[1:0] !== exp_p[i] || diff_n[1:0] !== ~exp_p[i]) begin
          n_fail++; $display("FAIL single_pads i=%0d got p=%b n=%b want p=%b", i, diff_p[1:0], diff_n[1:0], exp_p[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_p [20];
    logic acc;
    int n_acc;
    exp_p = '{2'b00, 2'b00,
              2'b10, 2'b00, 2'b11, 2'b01, 2'b01, 2'b11, 2'b00, 2'b10,
              2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01,
              2'b00, 2'b00};
    n_acc = 0;
    in_data = 16'hA53C; in_valid = 1'b1;
    step();
    in_data = 16'h0FF0;
    for (int i = 0; i < 21; i++) begin
      if (i > 0) begin
        acc = in_valid && in_ready;
        step();
        if (acc) begin in_valid = 1'b0; n_acc++; end
      end
      n_tests++;
      if (in_ready !== (i == 9 || i == 17 || i == 20)) begin
        n_fail++; $display("FAIL b2b_ready i=%0d got %b want %b", i, in_ready, (i == 9 || i == 17 || i == 20));
      end
      n_tests++;
      if (dut.pad_t !== (i == 20)) begin n_fail++; $display("FAIL b2b_t i=%0d got %b want %b", i, dut.pad_t, (i == 20)); end
      if (i < 20) begin
        n_tests++;
        if (diff_p[1:0] !== exp_p[i] || diff_n[1:0] !== ~exp_p[i]) begin
          n_fail++; $display("FAIL b2b_pads i=%0d got p=%b n=%b want p=%b", i, diff_p[1:0], diff_n[1:0], exp_p[i]);
        end
      end
    end
    n_tests++;
    if (n_acc !== 1) begin n_fail++; $display("FAIL b2b_accepts got %0d want 1", n_acc); end
  endtask

  task automatic test_abort();
    in_data = 16'hA53C; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) step();
    n_tests++;
    if (dut.pad_t !== 1'b0 || diff_p[1:0] !== 2'b01) begin
      n_fail++; $display("FAIL abort_bit3 got t=%b p=%b want t=0 p=01", dut.pad_t, diff_p[1:0]);
    end
    rst = 1'b1;
    step();
    n_tests++;
    if (dut.pad_t !== 1'b1) begin n_fail++; $display("FAIL abort_t got %b want 1", dut.pad_t); end
    n_tests++;
    if (state_dbg !== 2'd0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL abort_state got st=%0d busy=%b rdy=%b want 0/0/0", state_dbg, busy, in_ready);
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      n_tests++;
      if (dut.pad_t !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL abort_residual c=%0d got t=%b busy=%b rdy=%b want 1/0/1", c, dut.pad_t, busy, in_ready);
      end
    end
  endtask

  task automatic test_guard0();
    logic exp_b [4];
    exp_b = '{1'b1, 1'b0, 1'b0, 1'b1};
    in_data2 = 4'h9; in_valid2 = 1'b1;
    step();
    in_valid2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      n_tests++;
      if (dut2.pad_t !== (i == 4)) begin n_fail++; $display("FAIL g0_t i=%0d got %b want %b", i, dut2.pad_t, (i == 4)); end
      n_tests++;
      if (busy2 !== (i < 4)) begin n_fail++; $display("FAIL g0_busy i=%0d got %b want %b", i, busy2, (i < 4)); end
      n_tests++;
      if (in_ready2 !== (i >= 3)) begin n_fail++; $display("FAIL g0_ready i=%0d got %b want %b", i, in_ready2, (i >= 3)); end
      if (i < 4) begin
        n_tests++;
        if (diff_p2[0] !== exp_b[i] || diff_n2[0] !== ~exp_b[i]) begin
          n_fail++; $display("FAIL g0_pads i=%0d got p=%b n=%b want p=%b", i, diff_p2[0], diff_n2[0], exp_b[i]);
        end
      end
    end
  endtask

`ifdef DIFF_OBUFT_PARITY_EN
  task automatic test_parity();
    logic exp_par [12];
    exp_par = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    in_data = 16'hA53C; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (i > 0) step();
      if (i < 12) begin
        n_tests++;
        if (diff_p[2] !== exp_par[i] || diff_n[2] !== ~exp_par[i]) begin
          n_fail++; $display("FAIL parity i=%0d got p=%b n=%b want p=%b", i, diff_p[2], diff_n[2], exp_par[i]);
        end
      end
    end
  endtask
`endif

  // ---------------- sequence and final report ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_valid2 = 1'b0; in_data2 = '0;
    test_reset();
    test_single();
    step();
    test_back_to_back();
    step();
    test_abort();
    test_guard0();
    step();
`ifdef DIFF_OBUFT_PARITY_EN
    test_parity();
    step();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
